// File: rtl/wb_write_queue.sv
// Writeback queue in front of the single regfile write port: merges LSU and pipeline results in arrival order.
// Optional macro WB_FWD_EN adds rs/rt forwarding of queued data and suppresses pending stalls.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    input  logic        pipe_valid_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,
    output logic        pipe_ready_o,
    output logic        regfile_write_enable_o,
    output logic [4:0]  regfile_write_addr_o,
    output logic [31:0] regfile_write_data_o,
    input  logic [4:0]  rs_query_addr_i,
    input  logic [4:0]  rt_query_addr_i,
    output logic        rs_pending_o,
    output logic        rt_pending_o,
    output logic        rs_fwd_valid_o,
    output logic        rt_fwd_valid_o,
    output logic [31:0] rs_fwd_data_o,
    output logic [31:0] rt_fwd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             not_empty;
    logic [CNT_W:0]   free;
    logic             lsu_accept;
    logic             pipe_accept;
    logic             lsu_enq;
    logic             pipe_enq;
    logic [PTR_W-1:0] pipe_slot;

    assign not_empty = (count != '0);

    // The head is popped this edge, so its slot is already usable by an incoming request.
    assign free = (CNT_W+1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, not_empty};

    assign lsu_ready_o  = reset_i && (free >= (CNT_W+1)'(1));
    assign pipe_ready_o = reset_i && (lsu_valid_i ? (free >= (CNT_W+1)'(2))
                                                  : (free >= (CNT_W+1)'(1)));

    assign lsu_accept  = lsu_valid_i  && lsu_ready_o;
    assign pipe_accept = pipe_valid_i && pipe_ready_o;
    assign lsu_enq     = lsu_accept  && (lsu_addr_i  != 5'd0);
    assign pipe_enq    = pipe_accept && (pipe_addr_i != 5'd0);
    assign pipe_slot   = tail + PTR_W'(lsu_enq);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(not_empty);
            tail  <= tail + PTR_W'(lsu_enq) + PTR_W'(pipe_enq);
            count <= count + CNT_W'(lsu_enq) + CNT_W'(pipe_enq) - CNT_W'(not_empty);
        end
    end

    // LSU is older than the pipeline result when both arrive together.
    always_ff @(posedge clock_i) begin
        if (lsu_enq) begin
            addr_q[tail] <= lsu_addr_i;
            data_q[tail] <= lsu_data_i;
        end
        if (pipe_enq) begin
            addr_q[pipe_slot] <= pipe_addr_i;
            data_q[pipe_slot] <= pipe_data_i;
        end
    end

    assign regfile_write_enable_o = not_empty;
    assign regfile_write_addr_o   = not_empty ? addr_q[head] : 5'd0;
    assign regfile_write_data_o   = not_empty ? data_q[head] : 32'd0;

    logic             rs_hit;
    logic             rt_hit;
    logic [PTR_W-1:0] idx;
`ifdef WB_FWD_EN
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
`endif

    // Scan non-head entries oldest to youngest so the last match wins; the head is bypassed by the regfile.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        idx    = '0;
`ifdef WB_FWD_EN
        rs_data = 32'd0;
        rt_data = 32'd0;
`endif
        for (int k = 1; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (addr_q[idx] == rs_query_addr_i) begin
                    rs_hit = 1'b1;
`ifdef WB_FWD_EN
                    rs_data = data_q[idx];
`endif
                end
                if (addr_q[idx] == rt_query_addr_i) begin
                    rt_hit = 1'b1;
`ifdef WB_FWD_EN
                    rt_data = data_q[idx];
`endif
                end
            end
        end
        if (rs_query_addr_i == 5'd0) rs_hit = 1'b0;
        if (rt_query_addr_i == 5'd0) rt_hit = 1'b0;
    end

`ifdef WB_FWD_EN
    assign rs_fwd_valid_o = rs_hit;
    assign rt_fwd_valid_o = rt_hit;
    assign rs_fwd_data_o  = rs_data;
    assign rt_fwd_data_o  = rt_data;
    // Every queued match is forwarded, so decode never needs to stall.
    assign rs_pending_o   = rs_hit && !rs_fwd_valid_o;
    assign rt_pending_o   = rt_hit && !rt_fwd_valid_o;
`else
    assign rs_fwd_valid_o = 1'b0;
    assign rt_fwd_valid_o = 1'b0;
    assign rs_fwd_data_o  = 32'd0;
    assign rt_fwd_data_o  = 32'd0;
    assign rs_pending_o   = rs_hit;
    assign rt_pending_o   = rt_hit;
`endif

endmodule

// File: doc/wb_write_queue.md
# wb_write_queue

Writeback queue that sits in front of the register file's single write port. It accepts writeback results from two producers, the in-order pipeline (ALU/MEM-stage result) and the load/store unit (late load data), and buffers them in program-arrival order in a small FIFO. It drains exactly one entry per cycle into the regfile write port. It also gives decode a pending-write lookup for rs/rt so decode can stall on results not yet visible through the regfile's own write-to-read bypass.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- clock_i  input  1  system clock, rising edge
- reset_i  input  1  asynchronous, active-low reset
- lsu_valid_i  input  1  LSU writeback request
- lsu_addr_i  input  5  LSU destination register
- lsu_data_i  input  32  LSU result
- lsu_ready_o  output  1  LSU request accepted this cycle when high with valid
- pipe_valid_i  input  1  pipeline writeback request
- pipe_addr_i  input  5  pipeline destination register
- pipe_data_i  input  32  pipeline result
- pipe_ready_o  output  1  pipeline request accepted when high with valid
- regfile_write_enable_o  output  1  regfile write strobe
- regfile_write_addr_o  output  5  regfile write address
- regfile_write_data_o  output  32  regfile write data
- rs_query_addr_i  input  5  decode rs lookup
- rt_query_addr_i  input  5  decode rt lookup
- rs_pending_o  output  1  rs has an unwritten, unbypassed result queued
- rt_pending_o  output  1  same for rt
- rs_fwd_valid_o, rt_fwd_valid_o  output  1  forward hit (WB_FWD_EN only)
- rs_fwd_data_o, rt_fwd_data_o  output  32  forwarded data (WB_FWD_EN only)

## Operation
- Storage: circular FIFO of {addr[4:0], data[31:0]}, head/tail pointers of log2(DEPTH) bits with natural wrap, count of $clog2(DEPTH+1) bits.
- Drain: while count != 0, the head entry drives regfile_write_*_o with enable=1 and is popped at the next edge. The regfile always accepts writes, so there is no backpressure. When empty, enable=0, addr=0, data=0.
- Free slots this cycle: free = DEPTH - count + (count != 0).
- lsu_ready_o = (free >= 1). pipe_ready_o = (free >= 2) when lsu_valid_i is high, else (free >= 1). There is a combinational path from lsu_valid_i to pipe_ready_o. Ready never depends on addr.
- Same-cycle acceptance of both requests: the LSU entry is enqueued first (older), then the pipeline entry.
- Writes to $0 are accepted (the handshake completes) but are not enqueued.
- Count update per edge: +accepted nonzero-address entries, -1 if count was nonzero.
- Pending lookup (combinational): x_pending_o = (query != 0) and query matches any valid entry other than the head. A head match is covered by the regfile's write-to-read bypass.

## Timing
- Enqueue latency: a request accepted at edge N appears on regfile_write_*_o in cycle N+1 at the earliest (queue empty). The regfile commits it at edge N+1.
- Sustained rate is 1 write per cycle. Burst input is 2 per cycle until full.
- Full (count == DEPTH): lsu_ready_o = 1 (the pop frees a slot) and pipe_ready_o = !lsu_valid_i. No overflow is possible.
- Empty with both requests valid: both are accepted. The LSU entry drains in N+1 and the pipe entry in N+2.
- Reset asserted at any time (including mid-burst): pointers, count, and all outputs go to 0 immediately. Queued entries are discarded. Both ready signals read 1 from the first cycle after release.
- Reset values: regfile_write_enable_o=0, addr=0, data=0, pending=0, fwd_valid=0, fwd_data=0. lsu_ready_o and pipe_ready_o are held 0 while reset is asserted.

## Configuration
- WB_FWD_EN defined:
  - x_fwd_valid_o=1 and x_fwd_data_o = data of the youngest non-head entry matching a nonzero query.
  - x_pending_o is forced to 0 on a forward hit, so decode never stalls on queued results.
- WB_FWD_EN undefined:
  - fwd outputs are tied to 0 and the matching logic is removed.
  - pending behaves as described in Operation.

## Test plan
- Reset, then LSU writes $5=0x1234 alone: enable=1, addr=5, data=0x00001234 exactly one cycle later, then enable=0.
- LSU $3=0xA and pipe $3=0xB in the same cycle:
  - Writes appear on consecutive cycles, A then B.
  - In the cycle A is at the head, rt_query=3 gives rt_pending_o=1 (fwd build: fwd_data=0xB, pending=0).
- Both sources valid every cycle with DEPTH=4:
  - Count reaches 4, pipe_ready_o drops while lsu_ready_o stays 1.
  - One write per cycle, with no loss or reordering across the pointer wrap.
- Pipe write to $0 with data 0xFFFFFFFF: pipe_ready_o=1, no regfile write, count unchanged, rs_query=0 gives pending=0.
- Reset pulled low with 3 entries queued: outputs are 0 immediately, and after release the first new request is the next write seen.
